// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, stage numbers,
// ALU operations, immediate formats and the datapath select codes.
package rv32i_ctrl_pkg;

    localparam int STAGE_BITS = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [STAGE_BITS-1:0] {
        ST_FETCH     = 5'd0,
        ST_DECODE    = 5'd1,
        ST_EXECUTE   = 5'd2,
        ST_WRITEBACK = 5'd3,
        ST_MEMORY    = 5'd4
    } stage_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_src_e;
    typedef enum logic [1:0] {MTOR_ALU = 2'd0, MTOR_MEM = 2'd1, MTOR_PC4 = 2'd2} mtor_e;
    typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_REL = 2'd2} pc_src_e;
    typedef enum logic [1:0] {SRCB_RS = 2'd0, SRCB_IMM = 2'd1, SRCB_4 = 2'd2} srcb_e;

    // Branch condition from funct3 and the ALU compare flags of rs1-rs2.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from opcode, funct3 and funct7[5].
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_ctrl_e  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (opcode == OP_BRANCH) begin
            alu_ctrl = ALU_SUB;
        end else if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                // Immediate forms carry imm[11:5] in funct7, so SUB only exists for R-type
                3'b000:  alu_ctrl = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctrl = ALU_SLL;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b011:  alu_ctrl = ALU_SLTU;
                3'b100:  alu_ctrl = ALU_XOR;
                3'b101:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctrl = ALU_OR;
                default: alu_ctrl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: latches the instruction, walks FETCH/DECODE/EXECUTE/
// MEMORY/WRITEBACK and drives the datapath selects and register-file strobes.
module multicycle_control
    import rv32i_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_IR = 32'h00000013,
    parameter int          STAGE_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               alu_zero,
    input  logic               alu_lt,
    input  logic               alu_ltu,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [STAGE_W-1:0] current_stage,
    output logic [1:0]         MtoR,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [3:0]         AluCtrl,
    output logic [2:0]         ImmSrc,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [2:0]         funct3,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               illegal_instr,
    output logic               instr_retired
);

    stage_e      state;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic        is_r, is_i, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
    logic        is_legal;
    alu_ctrl_e   dec_alu_ctrl;
    logic        unused_ir_bits;

    assign opcode    = ir[6:0];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                       is_lui | is_auipc | is_jal | is_jalr;

    // LUI reads x0 so the ADD in EXECUTE passes the upper immediate straight through
    assign rs1            = is_lui ? 5'd0 : ir[19:15];
    assign rs2            = ir[24:20];
    assign rd             = ir[11:7];
    assign funct3         = ir[14:12];
    assign current_stage  = STAGE_W'(state);
    assign unused_ir_bits = ^{ir[31], ir[29:25]};

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .funct3    (ir[14:12]),
        .funct7_b5 (ir[30]),
        .alu_ctrl  (dec_alu_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            ir    <= RESET_IR;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir    <= instr;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE:  state <= is_legal ? ST_EXECUTE : ST_FETCH;
                ST_EXECUTE: begin
                    if (is_branch)                 state <= ST_FETCH;
                    else if (is_load || is_store)  state <= ST_MEMORY;
                    else                           state <= ST_WRITEBACK;
                end
                ST_MEMORY: begin
                    if (dmem_ready) state <= is_store ? ST_FETCH : ST_WRITEBACK;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE:          ImmSrc = IMM_S;
            OP_BRANCH:         ImmSrc = IMM_B;
            OP_LUI, OP_AUIPC:  ImmSrc = IMM_U;
            OP_JAL:            ImmSrc = IMM_J;
            default:           ImmSrc = IMM_I;
        endcase
    end

    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        MtoR          = MTOR_ALU;
        RegWrite      = 1'b0;
        AluSrcA       = 1'b0;
        AluSrcB       = SRCB_RS;
        AluCtrl       = ALU_ADD;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        illegal_instr = 1'b0;
        instr_retired = 1'b0;
        case (state)
            ST_FETCH: imem_req = !reset;
            ST_DECODE: begin
                if (!is_legal) begin
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                end
            end
            ST_EXECUTE: begin
                AluCtrl = dec_alu_ctrl;
                AluSrcA = !(is_auipc || is_jal);
                AluSrcB = (is_r || is_branch) ? SRCB_RS : (is_jal ? SRCB_4 : SRCB_IMM);
                if (is_branch) begin
                    pc_write      = 1'b1;
                    pc_src        = branch_taken(ir[14:12], alu_zero, alu_lt, alu_ltu) ? PC_REL : PC_PLUS4;
                    instr_retired = 1'b1;
                end
            end
            ST_MEMORY: begin
                dmem_req      = 1'b1;
                dmem_we       = is_store;
                pc_write      = is_store && dmem_ready;
                instr_retired = is_store && dmem_ready;
            end
            ST_WRITEBACK: begin
                RegWrite      = (rd != 5'd0);
                MtoR          = is_load ? MTOR_MEM : ((is_jal || is_jalr) ? MTOR_PC4 : MTOR_ALU);
                pc_write      = 1'b1;
                pc_src        = is_jal ? PC_REL : (is_jalr ? PC_ALU : PC_PLUS4);
                instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions checked cycle by cycle
// against a per-instruction expected stage trace built from the instruction-class rules.
module tb_multicycle_control;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [31:0] RESET_IR = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, alu_zero, alu_lt, alu_ltu;
    logic        imem_req, dmem_req, dmem_we;
    logic [4:0]  current_stage;
    logic [1:0]  MtoR;
    logic        RegWrite, AluSrcA;
    logic [1:0]  AluSrcB;
    logic [3:0]  AluCtrl;
    logic [2:0]  ImmSrc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        illegal_instr, instr_retired;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .current_stage(current_stage), .MtoR(MtoR),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluCtrl(AluCtrl),
        .ImmSrc(ImmSrc), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .pc_write(pc_write),
        .pc_src(pc_src), .illegal_instr(illegal_instr), .instr_retired(instr_retired)
    );

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we;
        logic [4:0] stage;
        logic [1:0] mtor;
        logic       reg_write, src_a;
        logic [1:0] src_b;
        logic [3:0] alu_ctrl;
        logic [2:0] imm_src;
        logic [4:0] rs1, rs2, rd;
        logic [2:0] funct3;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       illegal, retired;
    } out_t;

    typedef struct {
        logic        imem_ready;
        logic        dmem_ready;
        logic [31:0] instr;
        out_t        exp;
    } step_t;

    step_t       trace[$];
    logic [31:0] model_ir;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t sample();
        return {imem_req, dmem_req, dmem_we, current_stage, MtoR, RegWrite, AluSrcA, AluSrcB,
                AluCtrl, ImmSrc, rs1, rs2, rd, funct3, pc_write, pc_src, illegal_instr, instr_retired};
    endfunction

    // Fields that follow the latched instruction in every stage.
    function automatic out_t ir_view(input logic [31:0] ir);
        out_t o = '0;
        o.rs1    = (ir[6:0] == OP_LUI) ? 5'd0 : ir[19:15];
        o.rs2    = ir[24:20];
        o.rd     = ir[11:7];
        o.funct3 = ir[14:12];
        case (ir[6:0])
            OP_STORE:         o.imm_src = 3'd1;
            OP_BRANCH:        o.imm_src = 3'd2;
            OP_LUI, OP_AUIPC: o.imm_src = 3'd3;
            OP_JAL:           o.imm_src = 3'd4;
            default:          o.imm_src = 3'd0;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [31:0] ir);
        logic [3:0] by_f3 [8];
        logic [3:0] r;
        by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (ir[6:0] == OP_BRANCH) return 4'd1;
        if (ir[6:0] != OP_R && ir[6:0] != OP_I) return 4'd0;
        r = by_f3[ir[14:12]];
        if (ir[14:12] == 3'd5 && ir[30]) r = 4'd7;
        if (ir[14:12] == 3'd0 && ir[30] && ir[6:0] == OP_R) r = 4'd1;
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int spec_cycles(input logic [31:0] ins, input int iw, input int dw);
        case (ins[6:0])
            OP_BRANCH: return 3 + iw;
            OP_LOAD:   return 5 + iw + dw;
            OP_STORE:  return 4 + iw + dw;
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 4 + iw;
            default:   return 2 + iw;
        endcase
    endfunction

    task automatic push(input out_t o, input logic dr);
        step_t s;
        s.imem_ready = 1'($urandom);
        s.dmem_ready = dr;
        s.instr      = $urandom;
        s.exp        = o;
        trace.push_back(s);
    endtask

    task automatic build(input logic [31:0] ins, input int iw, input int dw);
        out_t        o;
        step_t       s;
        logic [6:0]  op = ins[6:0];
        logic        legal;
        legal = (op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH ||
                 op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR);
        trace.delete();
        for (int i = 0; i <= iw; i++) begin
            o = ir_view(model_ir);
            o.imem_req   = 1'b1;
            s.imem_ready = (i == iw);
            s.dmem_ready = 1'($urandom);
            s.instr      = (i == iw) ? ins : $urandom;
            s.exp        = o;
            trace.push_back(s);
        end
        model_ir = ins;
        o = ir_view(ins);
        o.stage = 5'd1;
        if (!legal) begin
            o.illegal  = 1'b1;
            o.pc_write = 1'b1;
            push(o, 1'($urandom));
            return;
        end
        push(o, 1'($urandom));
        o = ir_view(ins);
        o.stage    = 5'd2;
        o.alu_ctrl = ref_alu(ins);
        case (op)
            OP_R, OP_BRANCH: begin o.src_a = 1'b1; o.src_b = 2'd0; end
            OP_AUIPC:        begin o.src_a = 1'b0; o.src_b = 2'd1; end
            OP_JAL:          begin o.src_a = 1'b0; o.src_b = 2'd2; end
            default:         begin o.src_a = 1'b1; o.src_b = 2'd1; end
        endcase
        if (op == OP_BRANCH) begin
            o.pc_write = 1'b1;
            o.pc_src   = ref_taken(ins[14:12], alu_zero, alu_lt, alu_ltu) ? 2'd2 : 2'd0;
            o.retired  = 1'b1;
            push(o, 1'($urandom));
            return;
        end
        push(o, 1'($urandom));
        if (op == OP_LOAD || op == OP_STORE) begin
            for (int i = 0; i <= dw; i++) begin
                o = ir_view(ins);
                o.stage    = 5'd4;
                o.dmem_req = 1'b1;
                o.dmem_we  = (op == OP_STORE);
                if (i == dw && op == OP_STORE) begin
                    o.pc_write = 1'b1;
                    o.retired  = 1'b1;
                end
                push(o, i == dw);
            end
            if (op == OP_STORE) return;
        end
        o = ir_view(ins);
        o.stage     = 5'd3;
        o.reg_write = (ins[11:7] != 5'd0);
        o.mtor      = (op == OP_LOAD) ? 2'd1 : ((op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0);
        o.pc_write  = 1'b1;
        o.pc_src    = (op == OP_JAL) ? 2'd2 : ((op == OP_JALR) ? 2'd1 : 2'd0);
        o.retired   = 1'b1;
        push(o, 1'($urandom));
    endtask

    task automatic run(input string name, input int steps, input int exp_cycles);
        int done_at = -1;
        for (int i = 0; i < steps; i++) begin
            imem_ready = trace[i].imem_ready;
            dmem_ready = trace[i].dmem_ready;
            instr      = trace[i].instr;
            @(negedge clk);
            chk({name, "/stage"}, 64'(current_stage), 64'(trace[i].exp.stage));
            chk({name, "/outputs"}, 64'(sample()), 64'(trace[i].exp));
            if (done_at < 0 && (instr_retired || illegal_instr)) done_at = i + 1;
            @(posedge clk);
            #1;
        end
        if (steps == trace.size()) chk({name, "/cycles"}, 64'(done_at), 64'(exp_cycles));
    endtask

    task automatic do_instr(input string name, input logic [31:0] ins, input int iw, input int dw,
                            input logic z, input logic lt, input logic ltu);
        alu_zero = z;
        alu_lt   = lt;
        alu_ltu  = ltu;
        build(ins, iw, dw);
        run(name, trace.size(), spec_cycles(ins, iw, dw));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        logic [6:0]  ops [9];
        logic [6:0]  bad [4];
        logic [2:0]  bf3 [6];
        int          cls;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        bad = '{7'h7F, 7'h0F, 7'h73, 7'h00};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        cls = $urandom_range(0, 9);
        if (cls == 9) ins[6:0] = bad[$urandom_range(0, 3)];
        else          ins[6:0] = ops[cls];
        if (ins[6:0] == OP_BRANCH) ins[14:12] = bf3[$urandom_range(0, 5)];
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        out_t o;
        reset = 1'b1;
        instr = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero = 1'b0;
        alu_lt = 1'b0;
        alu_ltu = 1'b0;
        model_ir = RESET_IR;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/outputs", 64'(sample()), 64'(ir_view(RESET_IR)));
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_instr("add_x25", 32'h00518CB3, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr("lw_wait3", 32'h008A2483, 0, 3, 1'b0, 1'b0, 1'b0);
        do_instr("beq_taken", {7'd0, 5'd21, 5'd20, 3'd0, 5'd8, OP_BRANCH}, 0, 0, 1'b1, 1'b0, 1'b0);
        do_instr("beq_not", {7'd0, 5'd21, 5'd20, 3'd0, 5'd8, OP_BRANCH}, 1, 0, 1'b0, 1'b1, 1'b1);
        do_instr("jal_x1", 32'h010000EF, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr("addi_x0", 32'h00500013, 2, 0, 1'b0, 1'b0, 1'b0);
        do_instr("illegal", 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1'b0);

        // Reset while a store waits in MEMORY.
        build({7'd0, 5'd5, 5'd2, 3'd2, 5'd4, OP_STORE}, 0, 5);
        run("sw_reset", 5, 0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid/stage", 64'(current_stage), 64'd0);
        chk("rst_mid/dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_mid/pc_write", 64'(pc_write), 64'd0);
        chk("rst_mid/retired", 64'(instr_retired), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_ir = RESET_IR;
        o = ir_view(RESET_IR);
        o.imem_req = 1'b1;
        chk("rst_mid/after", 64'(sample()), 64'(o));
        @(posedge clk);
        #1;

        for (int n = 0; n < 200; n++) begin
            do_instr("random", rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
